aram_arbiter: RTL and testbench
===============================

// Module: aram_arbiter
// PURPOSE
//  Shares the single-port audio RAM (BRAM, 1-cycle registered read) between the SPC700 CPU and the DSP
//  sample/voice fetch engine. CPU has priority; DSP wins after DSP_MAX_WAIT consecutive losses (anti-starve).
//  Sits between CPU/DSP memory ports and the RAM macro; routes read data back to the access owner.
// PARAMETERS
//  ADDR_WIDTH    16  RAM address width (64 KiB audio RAM)
//  DATA_WIDTH    8   RAM data width
//  DSP_MAX_WAIT  3   consecutive DSP losses before DSP is forced to win; legal 1..15
// PORTS
//  clock        in   1   single system clock, all logic on rising edge
//  reset        in   1   synchronous, active-high
//  cpu_req      in   1   CPU access request; held with addr/we/wdata stable until cpu_gnt
//  cpu_addr     in   AW  CPU address
//  cpu_we       in   1   1=write, 0=read
//  cpu_wdata    in   DW  CPU write data
//  cpu_gnt      out  1   access issued to RAM this cycle (combinational from req + arbiter state)
//  cpu_rdata    out  DW  read data; valid only when cpu_rvalid
//  cpu_rvalid   out  1   pulses the cycle after a granted CPU read
//  dsp_req/addr/we/wdata/gnt/rdata/rvalid   same set and meaning for the DSP requester
//  mem_addr     out  AW  RAM address (registered-read macro samples on clock)
//  mem_wdata    out  DW  RAM write data
//  mem_we       out  1   RAM write enable
//  mem_re       out  1   RAM read enable (granted read)
//  mem_rdata    in   DW  RAM read data, valid the cycle after mem_re
//  starve_cnt   out  4   current DSP consecutive-loss count (debug)
// BEHAVIOUR
//  - Reset (synchronous): starve_cnt=0, owner=NONE, cpu_rvalid=dsp_rvalid=0. While reset high all *_gnt=0,
//    mem_we=mem_re=0, mem_addr/mem_wdata=0; no access reaches RAM.
//  - At most one grant per cycle. Winner selection, cycle N:
//      force_dsp = dsp_req && starve_cnt >= DSP_MAX_WAIT
//      winner = force_dsp ? DSP : cpu_req ? CPU : dsp_req ? DSP : NONE
//  - Winner's addr/we/wdata drive mem_* in cycle N; mem_re = winner && !we; mem_we = winner && we.
//    With no winner mem_we=mem_re=0, mem_addr holds last value.
//  - starve_cnt: +1 when dsp_req && winner==CPU (saturate at 15); cleared when DSP granted or dsp_req low.
//  - Read return: owner register captures winner of a read in N; in N+1 owner's rvalid=1 and rdata=mem_rdata.
//    Writes produce no rvalid. Back-to-back reads from alternating requesters each get exactly one rvalid.
//  - rdata outputs pass mem_rdata whenever rvalid is 0 (value don't-care); benches check only on rvalid.
//  - Throughput: 1 access/cycle; latency grant->rvalid = 1 cycle; write is committed at the grant edge.
//  - Requester dropping req before grant: request withdrawn, no access; allowed.
//  - Reset asserted the cycle after a read grant: rvalid suppressed (forced 0), in-flight data discarded.
//  - Same-address write followed next cycle by read (either requester) returns new data (RAM WRITE_MODE ordering).
// CONFIGURATION
//  ARAM_ARB_DBG_PORT_EN defined: adds dbg_req/addr/we/wdata (in) and dbg_gnt/rdata/rvalid (out), same protocol;
//   debug port is highest priority (above force_dsp); starve_cnt frozen (neither incremented nor cleared)
//   in cycles the debug port wins. Used by the host boot loader to fill RAM while CPU is held.
//  Not defined: ports absent, arbitration exactly as above, no extra logic.
// TESTING
//  1. reset high 3 cycles with cpu_req=dsp_req=1 -> no gnt, mem_we=mem_re=0, starve_cnt=0, no rvalid.
//  2. CPU write 0x0123<-0xA5, next CPU read 0x0123 -> cpu_gnt both cycles, cpu_rvalid 1 cycle later, cpu_rdata=0xA5.
//  3. cpu_req and dsp_req held high, DSP_MAX_WAIT=3 -> grant order CPU,CPU,CPU,DSP,CPU,CPU,CPU,DSP; starve_cnt 0,1,2,3,0.
//  4. alternating CPU read 0x0010 (=0x11) / DSP read 0x0020 (=0x22) -> cpu_rvalid/dsp_rvalid alternate, data 0x11/0x22, never both.
//  5. DSP read granted, reset asserted next cycle -> dsp_rvalid=0, starve_cnt=0 after reset.
//  6. ARAM_ARB_DBG_PORT_EN: dbg_req with cpu/dsp req high, starve_cnt=3 -> dbg_gnt wins, starve_cnt stays 3, DSP wins next.

Source files
------------

// File: rtl/aram_arbiter.sv
// ============================================================================
// aram_arbiter: shares the single-port audio RAM between the CPU and the DSP
// fetch engine. CPU has priority; the DSP is forced through after
// DSP_MAX_WAIT consecutive losses. Read data is routed back to its owner.
// Optional macro ARAM_ARB_DBG_PORT_EN adds a highest-priority debug port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aram_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int DSP_MAX_WAIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  dsp_req,
  input  logic [ADDR_WIDTH-1:0] dsp_addr,
  input  logic                  dsp_we,
  input  logic [DATA_WIDTH-1:0] dsp_wdata,
  output logic                  dsp_gnt,
  output logic [DATA_WIDTH-1:0] dsp_rdata,
  output logic                  dsp_rvalid,
`ifdef ARAM_ARB_DBG_PORT_EN
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic                  dbg_we,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_rvalid,
`endif
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [3:0]            starve_cnt
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DSP  = 2'd2;
  localparam logic [1:0] OWN_DBG  = 2'd3;
  localparam logic [3:0] MAX_WAIT = 4'(DSP_MAX_WAIT);

  logic [1:0]            winner;
  logic                  force_dsp;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;

  logic [1:0]            owner_q, owner_d;
  logic [3:0]            starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [DATA_WIDTH-1:0] last_wdata_q, last_wdata_d;

  // Winner selection; nothing is granted while reset is high.
  always_comb begin
    force_dsp = dsp_req && (starve_q >= MAX_WAIT);
    winner    = OWN_NONE;
    if (!reset) begin
`ifdef ARAM_ARB_DBG_PORT_EN
      if (dbg_req)        winner = OWN_DBG;
      else
`endif
      if (force_dsp)      winner = OWN_DSP;
      else if (cpu_req)   winner = OWN_CPU;
      else if (dsp_req)   winner = OWN_DSP;
    end
  end

  always_comb begin
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    sel_we    = cpu_we;
    case (winner)
      OWN_DSP: begin
        sel_addr  = dsp_addr;
        sel_wdata = dsp_wdata;
        sel_we    = dsp_we;
      end
`ifdef ARAM_ARB_DBG_PORT_EN
      OWN_DBG: begin
        sel_addr  = dbg_addr;
        sel_wdata = dbg_wdata;
        sel_we    = dbg_we;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      starve_q     <= 4'd0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      last_addr_q  <= last_addr_d;
      last_wdata_q <= last_wdata_d;
    end
  end

  // Owner tracks the requester whose read returns next cycle.
  always_comb begin
    owner_d      = OWN_NONE;
    starve_d     = starve_q;
    last_addr_d  = last_addr_q;
    last_wdata_d = last_wdata_q;
    if (winner != OWN_NONE) begin
      last_addr_d  = sel_addr;
      last_wdata_d = sel_wdata;
      if (!sel_we) owner_d = winner;
    end
    if (winner == OWN_DBG) begin
      starve_d = starve_q;
    end else if (dsp_req && winner == OWN_CPU) begin
      starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
    end else if (winner == OWN_DSP || !dsp_req) begin
      starve_d = 4'd0;
    end
  end

  always_comb begin
    cpu_gnt    = (winner == OWN_CPU);
    dsp_gnt    = (winner == OWN_DSP);
    mem_re     = (winner != OWN_NONE) && !sel_we;
    mem_we     = (winner != OWN_NONE) && sel_we;
    mem_addr   = reset ? '0 : ((winner != OWN_NONE) ? sel_addr : last_addr_q);
    mem_wdata  = reset ? '0 : ((winner != OWN_NONE) ? sel_wdata : last_wdata_q);
    cpu_rvalid = !reset && (owner_q == OWN_CPU);
    dsp_rvalid = !reset && (owner_q == OWN_DSP);
    cpu_rdata  = mem_rdata;
    dsp_rdata  = mem_rdata;
    starve_cnt = reset ? 4'd0 : starve_q;
`ifdef ARAM_ARB_DBG_PORT_EN
    dbg_gnt    = (winner == OWN_DBG);
    dbg_rvalid = !reset && (owner_q == OWN_DBG);
    dbg_rdata  = mem_rdata;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_aram_arbiter.sv
// ============================================================================
// tb_aram_arbiter: directed and randomized bench for aram_arbiter with a
// behavioural RAM and a shadow-memory reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dsp_req, dsp_we, dsp_gnt, dsp_rvalid;
  logic [AW-1:0] dsp_addr;
  logic [DW-1:0] dsp_wdata, dsp_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re;
  logic [3:0]    starve_cnt;
`ifdef ARAM_ARB_DBG_PORT_EN
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  aram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DSP_MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_we(dsp_we), .dsp_wdata(dsp_wdata),
    .dsp_gnt(dsp_gnt), .dsp_rdata(dsp_rdata), .dsp_rvalid(dsp_rvalid),
`ifdef ARAM_ARB_DBG_PORT_EN
    .dbg_req(1'b0), .dbg_addr('0), .dbg_we(1'b0), .dbg_wdata('0),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  // Power-on RAM contents for never-written locations.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Registered-read RAM macro.
  logic [7:0] ram [int];
  always @(posedge clock) begin
    if (mem_re) mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_val(mem_addr);
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: 0=none, 1=cpu, 2=dsp.
  int         m_starve = 0;
  int         m_pend   = 0;
  logic [7:0] m_pend_data = 8'h00;
  logic [15:0] m_last_addr = 16'h0;
  logic [7:0] shadow [int];
  int         last_win = 0;
  logic       obs_dsp_gnt;

  task automatic step();
    int          win;
    logic        we;
    logic [15:0] a;
    logic [7:0]  wd;
    #1;
    win = 0;
    if (!reset) begin
      if (dsp_req && m_starve >= MAXW) win = 2;
      else if (cpu_req)                win = 1;
      else if (dsp_req)                win = 2;
    end
    we = (win == 2) ? dsp_we    : cpu_we;
    a  = (win == 2) ? dsp_addr  : cpu_addr;
    wd = (win == 2) ? dsp_wdata : cpu_wdata;

    check("cpu_gnt", cpu_gnt, win == 1);
    check("dsp_gnt", dsp_gnt, win == 2);
    check("mem_re", mem_re, win != 0 && !we);
    check("mem_we", mem_we, win != 0 && we);
    check("starve_cnt", starve_cnt, reset ? 0 : m_starve);
    check("cpu_rvalid", cpu_rvalid, !reset && m_pend == 1);
    check("dsp_rvalid", dsp_rvalid, !reset && m_pend == 2);
    if (!reset && m_pend == 1) check("cpu_rdata", cpu_rdata, m_pend_data);
    if (!reset && m_pend == 2) check("dsp_rdata", dsp_rdata, m_pend_data);
    check("mem_addr", mem_addr, reset ? 16'h0 : (win != 0 ? a : m_last_addr));
    if (reset || (win != 0 && we)) check("mem_wdata", mem_wdata, reset ? 8'h0 : wd);
    obs_dsp_gnt = dsp_gnt;
    last_win    = win;

    if (reset) begin
      m_starve    = 0;
      m_pend      = 0;
      m_last_addr = 16'h0;
    end else begin
      if (win != 0) m_last_addr = a;
      m_pend = (win != 0 && !we) ? win : 0;
      if (m_pend != 0) m_pend_data = shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
      if (win != 0 && we) shadow[int'(a)] = wd;
      if (dsp_req && win == 1)       m_starve = (m_starve >= 15) ? 15 : m_starve + 1;
      else if (win == 2 || !dsp_req) m_starve = 0;
    end
    @(posedge clock);
  endtask

  task automatic drive_cpu(input logic rq, input logic w, input logic [15:0] ad, input logic [7:0] d);
    cpu_req = rq; cpu_we = w; cpu_addr = ad; cpu_wdata = d;
  endtask

  task automatic drive_dsp(input logic rq, input logic w, input logic [15:0] ad, input logic [7:0] d);
    dsp_req = rq; dsp_we = w; dsp_addr = ad; dsp_wdata = d;
  endtask

  initial begin
    logic pattern [8];
    bit   keep;
    pattern = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held with both requesters active.
    reset = 1'b1;
    drive_cpu(1'b1, 1'b0, 16'h0040, 8'h00);
    drive_dsp(1'b1, 1'b0, 16'h0050, 8'h00);
    step();
    repeat (2) begin @(negedge clock); step(); end

    // CPU write then read-back of the same address.
    @(negedge clock); reset = 1'b0;
    drive_dsp(1'b0, 1'b0, 16'h0, 8'h0);
    drive_cpu(1'b1, 1'b1, 16'h0123, 8'hA5); step();
    @(negedge clock); drive_cpu(1'b1, 1'b0, 16'h0123, 8'h00); step();
    #2;
    check("t2_rvalid", cpu_rvalid, 1'b1);
    check("t2_rdata", cpu_rdata, 8'hA5);
    @(negedge clock); drive_cpu(1'b0, 1'b0, 16'h0, 8'h0); step();

    // Both requesters held: anti-starvation forces every fourth grant to DSP.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      drive_cpu(1'b1, 1'b0, 16'h0200, 8'h0);
      drive_dsp(1'b1, 1'b0, 16'h0300, 8'h0);
      step();
      check("t3_order", obs_dsp_gnt, pattern[i]);
    end

    // Seed 0x0010/0x0020, then alternate CPU/DSP reads.
    @(negedge clock); drive_dsp(1'b0, 1'b0, 16'h0, 8'h0);
    drive_cpu(1'b1, 1'b1, 16'h0010, 8'h11); step();
    @(negedge clock); drive_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    drive_dsp(1'b1, 1'b1, 16'h0020, 8'h22); step();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i % 2 == 0) begin
        drive_cpu(1'b1, 1'b0, 16'h0010, 8'h0); drive_dsp(1'b0, 1'b0, 16'h0, 8'h0);
      end else begin
        drive_cpu(1'b0, 1'b0, 16'h0, 8'h0); drive_dsp(1'b1, 1'b0, 16'h0020, 8'h0);
      end
      step();
    end

    // DSP read granted, then reset in the return cycle.
    @(negedge clock); drive_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    drive_dsp(1'b1, 1'b0, 16'h0020, 8'h0); step();
    @(negedge clock); reset = 1'b1; drive_dsp(1'b0, 1'b0, 16'h0, 8'h0); step();
    @(negedge clock); reset = 1'b0; step();
    check("t5_starve", starve_cnt, 4'd0);

    // Randomized traffic; unserved requests are normally held, sometimes withdrawn.
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 59) == 0);
      keep = cpu_req && last_win != 1 && ($urandom_range(0, 7) != 0);
      if (!keep) drive_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           16'h0100 + 16'($urandom_range(0, 7)), 8'($urandom));
      keep = dsp_req && last_win != 2 && ($urandom_range(0, 7) != 0);
      if (!keep) drive_dsp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           16'h0100 + 16'($urandom_range(0, 7)), 8'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
